tt_nco_dco: RTL

- Synthesizable, parametrised successor to the ring-oscillator DCO: a numerically controlled oscillator clocked from the system clock.
- A phase accumulator advances by a frequency control word (FCW) derived from the signed PI-controller output.
- Produces a glitch-free square clock plus NUM_PHASES evenly spaced phase outputs, a wrap tick, and a saturation flag.
- Sits between the PI controller and the clock consumers of the loop.

---
 rtl/tt_nco_dco.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/tt_nco_dco.sv
// tt_nco_dco: numerically controlled oscillator clocked from the system clock.
// A phase accumulator advances by a clamped frequency control word derived
// from the signed PI-controller output. It produces a square clock, evenly
// spaced phase taps, a wrap tick and a saturation flag.
// Optional feature: define DCO_DITHER_EN to add LFSR-based +/-1 FCW dither.
module tt_nco_dco #(
    parameter int               CTRL_W     = 16,
    parameter int               ACC_W      = 24,
    parameter logic [ACC_W-1:0] CENTER_FCW = 24'h040000,
    parameter int               GAIN_SHIFT = 4,
    parameter int               NUM_PHASES = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_enable,
    input  logic signed [CTRL_W-1:0] i_control,
    input  logic                     i_ctrl_valid,
    output logic                     o_ctrl_ready,
    output logic                     o_clk_gen,
    output logic [NUM_PHASES-1:0]    o_phase,
    output logic                     o_tick,
    output logic                     o_active,
    output logic                     o_sat
);

    localparam int SUM_W    = ACC_W + CTRL_W + GAIN_SHIFT;
    localparam int PH_SHIFT = ACC_W - $clog2(NUM_PHASES);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic signed [SUM_W-1:0] FCW_MIN    = SUM_W'(1);
    localparam logic signed [SUM_W-1:0] FCW_MAX    = SUM_W'(1) << (ACC_W - 1);
    localparam logic signed [SUM_W-1:0] CENTER_EXT = {{(SUM_W-ACC_W){1'b0}}, CENTER_FCW};

    // Returns {clamped_flag, fcw}; fcw is limited to [1, 2^(ACC_W-1)] so the
    // oscillator never stalls and never exceeds the two-cycle minimum period.
    function automatic logic [ACC_W:0] clampFcw(input logic signed [SUM_W-1:0] raw);
        logic [ACC_W:0] res;
        if (raw < FCW_MIN) begin
            res = {1'b1, ACC_W'(1)};
        end else if (raw > FCW_MAX) begin
            res = {1'b1, FCW_MAX[ACC_W-1:0]};
        end else begin
            res = {1'b0, raw[ACC_W-1:0]};
        end
        return res;
    endfunction

    localparam logic [ACC_W:0] RESET_CLAMP = clampFcw(CENTER_EXT);

    logic [1:0]            state_q, state_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [ACC_W-1:0]      fcw_q, fcw_d;
    logic                  sat_q, sat_d;
    logic                  pend_q, pend_d;
    logic [ACC_W-1:0]      pendFcw_q, pendFcw_d;
    logic                  pendSat_q, pendSat_d;
    logic                  tick_q, tick_d;
    logic [NUM_PHASES-1:0] phase_q, phase_d;

    logic signed [SUM_W-1:0] ctrlExt;
    logic signed [SUM_W-1:0] fcwRaw;
    logic [ACC_W:0]          clampRes;
    logic [ACC_W:0]          effFcw;
    logic [ACC_W:0]          accSum;
    logic                    wrapEvt;
    logic                    accept;
    logic [ACC_W-1:0]        phSum;

`ifdef DCO_DITHER_EN
    logic [15:0]    lfsr_q, lfsr_d;
    logic [ACC_W:0] ditherAdd;

    // Fibonacci LFSR advances while oscillating; its low bits pick a +1/-1/0 FCW dither
    always_comb begin
        lfsr_d = lfsr_q;
        if (state_q != ST_IDLE) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
        unique case (lfsr_q[1:0])
            2'b01:   ditherAdd = (ACC_W+1)'(1);
            2'b10:   ditherAdd = {(ACC_W+1){1'b1}};
            default: ditherAdd = '0;
        endcase
        effFcw = {1'b0, fcw_q} + ditherAdd;
    end

    // LFSR register restarts from a fixed seed on reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    // Without dither the accumulator step is exactly the active FCW
    always_comb effFcw = {1'b0, fcw_q};
`endif

    // Control-to-FCW mapping: centre word plus shifted signed control, then clamp
    always_comb begin
        ctrlExt  = {{(SUM_W-CTRL_W){i_control[CTRL_W-1]}}, i_control};
        fcwRaw   = CENTER_EXT + (ctrlExt <<< GAIN_SHIFT);
        clampRes = clampFcw(fcwRaw);
    end

    // Accumulator step, wrap detection and run/drain/idle sequencing
    always_comb begin
        accSum  = {1'b0, acc_q} + effFcw;
        wrapEvt = (state_q != ST_IDLE) && accSum[ACC_W];
        state_d = state_q;
        acc_d   = acc_q;
        unique case (state_q)
            ST_IDLE: begin
                acc_d = '0;
                if (i_enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                acc_d = accSum[ACC_W-1:0];
                if (!i_enable) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                acc_d = accSum[ACC_W-1:0];
                if (i_enable) begin
                    state_d = ST_RUN;
                end else if (accSum[ACC_W]) begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                acc_d   = '0;
            end
        endcase
        tick_d = wrapEvt;
    end

    // Phase taps sample the next accumulator value offset by k/NUM_PHASES of a turn
    always_comb begin
        phase_d = '0;
        phSum   = '0;
        for (int k = 0; k < NUM_PHASES; k++) begin
            phSum      = acc_d + (ACC_W'(k) << PH_SHIFT);
            phase_d[k] = (state_d == ST_IDLE) ? 1'b0 : phSum[ACC_W-1];
        end
    end

    // Handshake: idle loads immediately, running words wait for a wrap to stay glitch-free
    always_comb begin
        o_ctrl_ready = !i_rst && !pend_q;
        accept       = i_ctrl_valid && o_ctrl_ready;
        fcw_d        = fcw_q;
        sat_d        = sat_q;
        pend_d       = pend_q;
        pendFcw_d    = pendFcw_q;
        pendSat_d    = pendSat_q;
        if (accept && (state_q == ST_IDLE)) begin
            fcw_d = clampRes[ACC_W-1:0];
            sat_d = clampRes[ACC_W];
        end else if (accept) begin
            pend_d    = 1'b1;
            pendFcw_d = clampRes[ACC_W-1:0];
            pendSat_d = clampRes[ACC_W];
        end
        if (pend_q && wrapEvt) begin
            fcw_d  = pendFcw_q;
            sat_d  = pendSat_q;
            pend_d = 1'b0;
        end
    end

    // State and datapath registers; reset aborts immediately and drops all outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            fcw_q     <= RESET_CLAMP[ACC_W-1:0];
            sat_q     <= 1'b0;
            pend_q    <= 1'b0;
            pendFcw_q <= '0;
            pendSat_q <= 1'b0;
            tick_q    <= 1'b0;
            phase_q   <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            fcw_q     <= fcw_d;
            sat_q     <= sat_d;
            pend_q    <= pend_d;
            pendFcw_q <= pendFcw_d;
            pendSat_q <= pendSat_d;
            tick_q    <= tick_d;
            phase_q   <= phase_d;
        end
    end

    assign o_phase   = phase_q;
    assign o_clk_gen = phase_q[0];
    assign o_tick    = tick_q;
    assign o_active  = (state_q != ST_IDLE);
    assign o_sat     = sat_q;

endmodule
